nubus_initiator: RTL and testbench
==================================

NUBUS_INITIATOR -- requirements
Module: nubus_initiator

Interface
REQ-001 Parameter SLOT_BASE, default 8'hF9, cpu_addr[31:24] value that decodes to this slot.
REQ-002 Parameter TIMEOUT, default 8'd200, cycle limit for the ACCESS and RECOVER states.
REQ-003 Port clk, input, 1, sole clock; all logic is in this domain.
REQ-004 Port reset, input, 1, asynchronous, active-high.
REQ-005 Port cpu_req, input, 1, CPU cycle request, held high until cpu_ack or cpu_berr.
REQ-006 Port cpu_addr, input, 32, CPU byte address.
REQ-007 Port cpu_wdata, input, 16, write data.
REQ-008 Port cpu_be, input, 2, {upper, lower} byte enables, 1=active.
REQ-009 Port cpu_rw_n, input, 1, 1=read, 0=write.
REQ-010 Port cpu_rdata, output, 16, read data, valid in the cpu_ack cycle.
REQ-011 Port cpu_ack, output, 1, one-cycle completion pulse.
REQ-012 Port cpu_berr, output, 1, one-cycle bus-error pulse.
REQ-013 Port slot_addr, output, 32, address to the slot.
REQ-014 Port slot_wdata, output, 16, write data to the slot.
REQ-015 Port slot_be, output, 2, byte enables to the slot, {upper, lower}, 1=active.
REQ-016 Port slot_rw_n, output, 1, direction to the slot.
REQ-017 Port slot_select, output, 1, slot chip select.
REQ-018 Port slot_rdata, input, 16, slot read data.
REQ-019 Port slot_ack_n, input, 1, slot acknowledge, active-low.
REQ-020 Port slot_nmrq_n, input, 1, slot interrupt request, active-low, asynchronous.
REQ-021 Port irq_out, output, 1, synchronized interrupt, active-high.

Function
REQ-022 The FSM SHALL have states IDLE, ACCESS and RECOVER.
REQ-023 IDLE SHALL start a cycle on cpu_req=1 with armed=1.
- cpu_addr[31:24]==SLOT_BASE: latch addr, wdata, be and rw_n into the slot_* outputs, set slot_select=1, clear armed, go to ACCESS.
- Any other address: pulse cpu_berr the next cycle, clear armed, stay in IDLE.
REQ-024 armed SHALL set whenever cpu_req is sampled 0, so each request is issued exactly once.
REQ-025 slot_addr, slot_wdata, slot_be and slot_rw_n SHALL hold stable from the select rise until return to IDLE.
REQ-026 ACCESS SHALL sample slot_ack_n every cycle.
- On 0: capture slot_rdata into cpu_rdata (reads only; writes leave cpu_rdata unchanged), pulse cpu_ack, drop slot_select, go to RECOVER.
REQ-027 A 8-bit counter SHALL clear on entry to ACCESS and RECOVER.
- In ACCESS, counter==TIMEOUT-1 with slot_ack_n=1: drop slot_select, pulse cpu_berr, go to RECOVER.
REQ-028 If ack arrives in the same cycle as timeout, ack SHALL win: cpu_ack pulses and cpu_berr does not.
REQ-029 RECOVER SHALL return to IDLE on slot_ack_n sampled 1, or at counter==TIMEOUT-1 (stuck ack).
REQ-030 With a responder that acks one cycle after select, timing SHALL be:
- request sampled at edge N
- select high after N
- cpu_ack high after N+2
- IDLE after N+4
REQ-031 slot_nmrq_n SHALL pass through a two-flop synchronizer; irq_out is the inverted second stage (two-cycle latency).
REQ-032 cpu_ack and cpu_berr SHALL never be high together, and each SHALL be high for exactly one cycle per cycle.

Reset
REQ-033 reset SHALL asynchronously force the FSM to IDLE and set these outputs:
- slot_select=0, cpu_ack=0, cpu_berr=0, irq_out=0
- cpu_rdata=0, slot_addr=0, slot_wdata=0, slot_be=0, slot_rw_n=1
- armed=1, counter=0, synchronizer flops=1
REQ-034 Reset mid-cycle SHALL drop slot_select immediately and give no completion pulse.

Structure
REQ-035 Package nubus_pkg SHALL hold the FSM state enum, the SLOT_BASE and TIMEOUT defaults, and the byte-enable bit positions.
REQ-036 The two-flop synchronizer SHALL be sub-module nubus_sync2 (1-bit, reset value parameterized).

Verification
REQ-037 Read 0xF9000000 against a model responder returning 0xA55A with one-cycle ack -> cpu_rdata=0xA55A, cpu_ack after edge N+2, IDLE after N+4.
REQ-038 Write 0xF9000002, be=2'b10, data 0x1234 -> slot_be=2'b10, slot_rw_n=0, slot_wdata=0x1234, all stable until select drops; exactly one cpu_ack.
REQ-039 Responder never acks, TIMEOUT=8 -> cpu_berr one cycle, 8 cycles after select rise, select=0; no cpu_ack.
REQ-040 Request to 0x00400000 -> cpu_berr next cycle; slot_select never rises.
REQ-041 Hold cpu_req high for 10 cycles after cpu_ack -> no second slot cycle until cpu_req drops and rises again.
REQ-042 Assert reset during ACCESS -> select=0 immediately, no pulses; slot_nmrq_n=0 -> irq_out=1 two cycles later.

Source files
------------

// File: rtl/nubus_pkg.sv
// rtl/nubus_pkg.sv - shared types and defaults for the NuBus slot initiator
package nubus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } nubus_state_e;

  localparam logic [7:0] SLOT_BASE_DEFAULT = 8'hF9;
  localparam logic [7:0] TIMEOUT_DEFAULT   = 8'd200;

  localparam int BE_LOWER = 0;
  localparam int BE_UPPER = 1;

  function automatic logic slot_hit(input logic [31:0] addr, input logic [7:0] base);
    return addr[31:24] == base;
  endfunction

endpackage

// File: rtl/nubus_sync2.sv
// rtl/nubus_sync2.sv - two-flop synchronizer for a single asynchronous level
module nubus_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nubus_initiator.sv
// rtl/nubus_initiator.sv - CPU-to-slot bridge: decode, select, wait for ack or timeout, recover
module nubus_initiator
  import nubus_pkg::*;
#(
  parameter logic [7:0] SLOT_BASE = SLOT_BASE_DEFAULT,
  parameter logic [7:0] TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_be,
  input  logic        cpu_rw_n,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_berr,
  output logic [31:0] slot_addr,
  output logic [15:0] slot_wdata,
  output logic [1:0]  slot_be,
  output logic        slot_rw_n,
  output logic        slot_select,
  input  logic [15:0] slot_rdata,
  input  logic        slot_ack_n,
  input  logic        slot_nmrq_n,
  output logic        irq_out
);

  localparam logic [7:0] LAST_COUNT = TIMEOUT - 8'd1;

  nubus_state_e state, state_next;
  logic         armed;
  logic [7:0]   count;

  logic req_go, start_hit, start_miss;
  logic ack_seen, timed_out, recover_done;

  logic       select_d, ack_d, berr_d, latch_req, capture_rd, count_clear;
  logic [7:0] count_d;
  logic       nmrq_sync_n;

  always_comb begin
    req_go       = (state == ST_IDLE) && cpu_req && armed;
    start_hit    = req_go && slot_hit(cpu_addr, SLOT_BASE);
    start_miss   = req_go && !slot_hit(cpu_addr, SLOT_BASE);
    ack_seen     = (state == ST_ACCESS) && !slot_ack_n;
    // ack in the final cycle still wins over the timeout
    timed_out    = (state == ST_ACCESS) && slot_ack_n && (count == LAST_COUNT);
    recover_done = (state == ST_RECOVER) && (slot_ack_n || (count == LAST_COUNT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start_hit) state_next = ST_ACCESS;
      ST_ACCESS:  if (ack_seen || timed_out) state_next = ST_RECOVER;
      ST_RECOVER: if (recover_done) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    select_d    = 1'b0;
    ack_d       = 1'b0;
    berr_d      = 1'b0;
    latch_req   = 1'b0;
    capture_rd  = 1'b0;
    count_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        select_d    = start_hit;
        latch_req   = start_hit;
        berr_d      = start_miss;
        count_clear = 1'b1;
      end
      ST_ACCESS: begin
        select_d    = !(ack_seen || timed_out);
        ack_d       = ack_seen;
        berr_d      = timed_out;
        capture_rd  = ack_seen && slot_rw_n;
        count_clear = ack_seen || timed_out;
      end
      ST_RECOVER: begin
        count_clear = recover_done;
      end
      default: begin
        count_clear = 1'b1;
      end
    endcase
  end

  assign count_d = count_clear ? 8'd0 : count + 8'd1;

  // armed re-arms only after the CPU lets go of cpu_req, so one request issues once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b1;
    end else if (!cpu_req) begin
      armed <= 1'b1;
    end else if (req_go) begin
      armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= 8'd0;
      slot_select <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_berr    <= 1'b0;
      cpu_rdata   <= 16'd0;
      slot_addr   <= 32'd0;
      slot_wdata  <= 16'd0;
      slot_be     <= 2'b00;
      slot_rw_n   <= 1'b1;
    end else begin
      count       <= count_d;
      slot_select <= select_d;
      cpu_ack     <= ack_d;
      cpu_berr    <= berr_d;
      if (capture_rd) begin
        cpu_rdata <= slot_rdata;
      end
      if (latch_req) begin
        slot_addr  <= cpu_addr;
        slot_wdata <= cpu_wdata;
        slot_be    <= cpu_be;
        slot_rw_n  <= cpu_rw_n;
      end
    end
  end

  nubus_sync2 #(
    .RESET_VAL (1'b1)
  ) u_nmrq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (slot_nmrq_n),
    .q     (nmrq_sync_n)
  );

  assign irq_out = ~nmrq_sync_n;

endmodule

// File: tb/tb_nubus_initiator.sv
// tb/tb_nubus_initiator.sv - scoreboard bench for nubus_initiator with a behavioural slot responder
module tb_nubus_initiator;
  import nubus_pkg::*;

  localparam logic [7:0] TMO   = 8'd8;
  localparam logic [7:0] BASE  = 8'hF9;
  localparam int         NEVER = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [1:0]  cpu_be;
  logic        cpu_rw_n;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_berr;
  logic [31:0] slot_addr;
  logic [15:0] slot_wdata;
  logic [1:0]  slot_be;
  logic        slot_rw_n;
  logic        slot_select;
  logic [15:0] slot_rdata;
  logic        slot_ack_n;
  logic        slot_nmrq_n;
  logic        irq_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        is_ack;
    logic [15:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] model_rdata;
  int          resp_delay;
  int          resp_cnt;
  logic        sel_q;

  always #5 clk = ~clk;

  nubus_initiator #(
    .SLOT_BASE (BASE),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_be      (cpu_be),
    .cpu_rw_n    (cpu_rw_n),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .cpu_berr    (cpu_berr),
    .slot_addr   (slot_addr),
    .slot_wdata  (slot_wdata),
    .slot_be     (slot_be),
    .slot_rw_n   (slot_rw_n),
    .slot_select (slot_select),
    .slot_rdata  (slot_rdata),
    .slot_ack_n  (slot_ack_n),
    .slot_nmrq_n (slot_nmrq_n),
    .irq_out     (irq_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Registered slot model: sees select one cycle late, acks after resp_delay further cycles
  always @(negedge clk) sel_q = slot_select;

  always @(posedge clk) begin
    #1;
    if (reset || !sel_q) begin
      slot_ack_n = 1'b1;
      resp_cnt   = 0;
    end else if (resp_delay != NEVER) begin
      if (resp_cnt >= resp_delay) slot_ack_n = 1'b0;
      else resp_cnt++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (cpu_ack || cpu_berr)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: ack=%0b berr=%0b while nothing outstanding", cpu_ack, cpu_berr);
      end else begin
        e = exp_q.pop_front();
        if (cpu_ack !== e.is_ack || cpu_berr !== !e.is_ack || (e.is_ack && cpu_rdata !== e.rdata)) begin
          n_bad++;
          $display("FAIL completion: ack=%0b berr=%0b rdata=0x%h, expected ack=%0b berr=%0b rdata=0x%h",
                   cpu_ack, cpu_berr, cpu_rdata, e.is_ack, !e.is_ack, e.rdata);
        end
      end
    end
  end

  task automatic run_txn(input logic [31:0] addr, input logic [15:0] wdata, input logic [1:0] be,
                         input logic rw_n, input int delay, input logic [15:0] rdata,
                         input int hold_extra);
    logic hit, exp_ack, fields_ok, reissued;
    int   exp_k, exp_idle, done_k, sel_k, idle_k, k;
    hit       = addr[31:24] == BASE;
    exp_ack   = hit && (delay <= int'(TMO) - 2);
    exp_k     = !hit ? 0 : (exp_ack ? delay + 2 : int'(TMO));
    exp_idle  = exp_k + ((hit && exp_ack) ? 2 : 1);
    if (exp_ack && rw_n) model_rdata = rdata;
    exp_q.push_back('{exp_ack, model_rdata});

    resp_delay = delay;
    slot_rdata = rdata;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    cpu_be     = be;
    cpu_rw_n   = rw_n;
    cpu_req    = 1'b1;

    fields_ok = 1'b1;
    reissued  = 1'b0;
    done_k    = -1;
    sel_k     = -1;
    idle_k    = -1;
    k         = 0;
    while (k < 60 && (done_k < 0 || idle_k < 0 || cpu_req)) begin
      @(negedge clk);
      if (slot_select) begin
        if (done_k >= 0) reissued = 1'b1;
        else if (sel_k < 0) sel_k = k;
      end
      if (hit && sel_k >= 0 && idle_k < 0 && dut.state != ST_IDLE &&
          (slot_addr !== addr || slot_wdata !== wdata || slot_be !== be || slot_rw_n !== rw_n))
        fields_ok = 1'b0;
      if (done_k < 0 && (cpu_ack || cpu_berr)) done_k = k;
      else if (done_k >= 0 && idle_k < 0 && dut.state == ST_IDLE) idle_k = k;
      if (done_k >= 0 && k >= done_k + hold_extra) cpu_req = 1'b0;
      k++;
    end
    cpu_req = 1'b0;

    check("done_latency", done_k, exp_k);
    check("idle_latency", idle_k, exp_idle);
    check("select_rise", sel_k, hit ? 0 : -1);
    if (hit) check("slot_fields_stable", fields_ok, 1'b1);
    if (hold_extra > 0) check("no_reissue_while_held", reissued, 1'b0);
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          d;
    reset       = 1'b1;
    cpu_req     = 1'b0;
    cpu_addr    = 32'd0;
    cpu_wdata   = 16'd0;
    cpu_be      = 2'b00;
    cpu_rw_n    = 1'b1;
    slot_rdata  = 16'd0;
    slot_ack_n  = 1'b1;
    slot_nmrq_n = 1'b1;
    resp_delay  = 0;
    resp_cnt    = 0;
    sel_q       = 1'b0;
    model_rdata = 16'd0;
    #1;
    check("reset_ctrl {sel,ack,berr,irq,rw_n}", {27'd0, slot_select, cpu_ack, cpu_berr, irq_out, slot_rw_n}, 32'h1);
    check("reset_cpu_rdata", cpu_rdata, 32'd0);
    check("reset_slot_addr", slot_addr, 32'd0);
    check("reset_slot_wdata_be", {slot_wdata, 14'd0, slot_be}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_txn(32'hF900_0000, 16'h0000, 2'b11, 1'b1, 0, 16'hA55A, 0);
    run_txn(32'hF900_0002, 16'h1234, 2'b10, 1'b0, 0, 16'hFFFF, 0);
    run_txn(32'hF900_0010, 16'h0000, 2'b11, 1'b1, NEVER, 16'h5555, 0);
    run_txn(32'hF900_0020, 16'h0000, 2'b01, 1'b1, int'(TMO) - 2, 16'h0F0F, 0);
    run_txn(32'h0040_0000, 16'h0000, 2'b11, 1'b1, 0, 16'h1111, 0);
    run_txn(32'hF900_0030, 16'h0000, 2'b11, 1'b1, 1, 16'hC3C3, 10);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[31:24] = BASE;
      else if (a[31:24] == BASE) a[24] = ~a[24];
      d = $urandom_range(0, 7);
      if (d == 7) d = NEVER;
      run_txn(a, 16'($urandom), 2'($urandom_range(1, 3)), 1'($urandom), d, 16'($urandom),
              ($urandom_range(0, 3) == 0) ? 4 : 0);
    end

    // reset in the middle of an access
    resp_delay = NEVER;
    cpu_addr   = 32'hF900_0040;
    cpu_rw_n   = 1'b1;
    cpu_req    = 1'b1;
    repeat (3) @(negedge clk);
    check("select_before_reset", slot_select, 1'b1);
    reset   = 1'b1;
    cpu_req = 1'b0;
    #1;
    exp_q.delete();
    model_rdata = 16'd0;
    check("reset_mid_ctrl {sel,ack,berr}", {29'd0, slot_select, cpu_ack, cpu_berr}, 32'd0);
    check("reset_mid_rdata", cpu_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    d = 0;
    repeat (10) begin
      @(negedge clk);
      if (slot_select) d++;
    end
    check("no_select_after_reset", d, 0);

    slot_nmrq_n = 1'b0;
    @(negedge clk);
    check("irq_after_1_edge", irq_out, 1'b0);
    @(negedge clk);
    check("irq_after_2_edges", irq_out, 1'b1);
    slot_nmrq_n = 1'b1;
    repeat (2) @(negedge clk);
    check("irq_release", irq_out, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
